// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings, default timing and
// the auto-refresh state encoding.
package sdram_pkg;

    // Commands are {CS#, RAS#, CAS#, WE#}
    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam logic [3:0] CMD_PRE = 4'b0010;
    localparam logic [3:0] CMD_AR  = 4'b0001;
    localparam logic [3:0] CMD_MRS = 4'b0000;

    localparam int TRP_DEF  = 2;
    localparam int TRFC_DEF = 7;

    localparam logic [1:0]  BANK_ALL = 2'b11;
    localparam logic [12:0] ADDR_ALL = 13'h1fff;

    typedef enum logic [2:0] {
        AREF_IDLE,
        AREF_PRE,
        AREF_TRP,
        AREF_AR,
        AREF_TRFC,
        AREF_END
    } aref_state_t;

endpackage

// File: rtl/sdram_aref.sv
// Auto-refresh stage: periodic request to the arbiter, then precharge-all
// followed by AR_NUM auto-refresh commands once the request is granted.
module sdram_aref
    import sdram_pkg::*;
#(
    parameter int CNT_REF = 750,
    parameter int TRP     = TRP_DEF,
    parameter int TRFC    = TRFC_DEF,
    parameter int AR_NUM  = 2
) (
    input  logic        aref_clk,
    input  logic        aref_rst_n,
    input  logic        init_end,
    input  logic        aref_en,
    output logic        aref_req,
    output logic [3:0]  aref_cmd,
    output logic [1:0]  aref_bank,
    output logic [12:0] aref_addr,
    output logic        aref_end
);

    localparam int REF_W   = $clog2(CNT_REF);
    localparam int FSM_MAX = (TRP > TRFC) ? TRP : TRFC;
    localparam int FSM_W   = $clog2(FSM_MAX + 1);
    localparam int AR_W    = $clog2(AR_NUM + 1);

    aref_state_t      state;
    aref_state_t      next_state;
    logic [REF_W-1:0] cnt_ref;
    logic [FSM_W-1:0] cnt_fsm;
    logic [AR_W-1:0]  cnt_ar;
    logic             timer_exp;
    logic             grant;

    assign timer_exp = (cnt_ref == REF_W'(CNT_REF - 1));
    assign grant     = (state == AREF_IDLE) && (next_state == AREF_PRE);

    // Interval timer free-runs independently of the FSM
    always_ff @(posedge aref_clk) begin
        if (!aref_rst_n || !init_end || timer_exp) begin
            cnt_ref <= '0;
        end else begin
            cnt_ref <= cnt_ref + REF_W'(1);
        end
    end

    // A fresh expiry wins over the grant clear so a request is never lost
    always_ff @(posedge aref_clk) begin
        if (!aref_rst_n || !init_end) begin
            aref_req <= 1'b0;
        end else if (timer_exp) begin
            aref_req <= 1'b1;
        end else if (grant) begin
            aref_req <= 1'b0;
        end
    end

    always_ff @(posedge aref_clk) begin
        if (!aref_rst_n) begin
            state <= AREF_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (!init_end) begin
            next_state = AREF_IDLE;
        end else begin
            case (state)
                AREF_IDLE: if (aref_req && aref_en) next_state = AREF_PRE;
                AREF_PRE:  next_state = AREF_TRP;
                AREF_TRP:  if (cnt_fsm == FSM_W'(TRP - 1)) next_state = AREF_AR;
                AREF_AR:   next_state = AREF_TRFC;
                AREF_TRFC: begin
                    if (cnt_fsm == FSM_W'(TRFC - 1)) begin
                        next_state = (cnt_ar == AR_W'(AR_NUM)) ? AREF_END : AREF_AR;
                    end
                end
                AREF_END:  next_state = AREF_IDLE;
                default:   next_state = AREF_IDLE;
            endcase
        end
    end

    // Wait counter restarts on every state change
    always_ff @(posedge aref_clk) begin
        if (!aref_rst_n || !init_end || (state != next_state)) begin
            cnt_fsm <= '0;
        end else if ((state == AREF_TRP) || (state == AREF_TRFC)) begin
            cnt_fsm <= cnt_fsm + FSM_W'(1);
        end else begin
            cnt_fsm <= '0;
        end
    end

    always_ff @(posedge aref_clk) begin
        if (!aref_rst_n || !init_end || (state == AREF_IDLE)) begin
            cnt_ar <= '0;
        end else if (state == AREF_AR) begin
            cnt_ar <= cnt_ar + AR_W'(1);
        end
    end

    // Registered outputs; a dropped init_end suppresses commands and completion
    always_ff @(posedge aref_clk) begin
        if (!aref_rst_n) begin
            aref_cmd  <= CMD_NOP;
            aref_bank <= BANK_ALL;
            aref_addr <= ADDR_ALL;
            aref_end  <= 1'b0;
        end else begin
            aref_bank <= BANK_ALL;
            aref_addr <= ADDR_ALL;
            aref_end  <= init_end && (state == AREF_END);
            if (!init_end) begin
                aref_cmd <= CMD_NOP;
            end else begin
                case (state)
                    AREF_PRE: aref_cmd <= CMD_PRE;
                    AREF_AR:  aref_cmd <= CMD_AR;
                    default:  aref_cmd <= CMD_NOP;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sdram_aref.sv
// Scoreboard bench for sdram_aref: a default instance and a short-interval
// instance, with expected command/completion events queued per grant.
module tb_sdram_aref;
    import sdram_pkg::*;

    localparam int REF1 = 750;
    localparam int REF2 = 20;

    logic        aref_clk = 1'b0;
    logic        rst1_n, init1, en1;
    logic        req1, end1;
    logic [3:0]  cmd1;
    logic [1:0]  bank1;
    logic [12:0] addr1;
    logic        rst2_n, init2, en2;
    logic        req2, end2;
    logic [3:0]  cmd2;
    logic [1:0]  bank2;
    logic [12:0] addr2;

    int          edge_n = 0;
    int          checks = 0;
    int          failures = 0;
    int          q1[$];
    int          q2[$];
    bit          done2 = 1'b0;

    sdram_aref dut1 (
        .aref_clk(aref_clk), .aref_rst_n(rst1_n), .init_end(init1), .aref_en(en1),
        .aref_req(req1), .aref_cmd(cmd1), .aref_bank(bank1), .aref_addr(addr1),
        .aref_end(end1)
    );

    sdram_aref #(.CNT_REF(REF2)) dut2 (
        .aref_clk(aref_clk), .aref_rst_n(rst2_n), .init_end(init2), .aref_en(en2),
        .aref_req(req2), .aref_cmd(cmd2), .aref_bank(bank2), .aref_addr(addr2),
        .aref_end(end2)
    );

    always #5 aref_clk = ~aref_clk;
    always @(posedge aref_clk) edge_n++;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, edge_n);
        end
    endtask

    // Returns at the falling edge that follows rising edge k
    task automatic waitUntilEdge(input int k);
        while (edge_n < k) @(negedge aref_clk);
    endtask

    task automatic applyStimulus(input logic rst_n, input logic init, input logic en);
        rst1_n = rst_n;
        init1  = init;
        en1    = en;
    endtask

    // Events encoded as kind*100000 + edge: 1=PRE, 2=AR, 3=END, 9=bad
    task automatic pushSequence(input int which, input int g);
        int evs[$];
        evs.push_back(100000 + g + 1);
        for (int k = 0; k < 2; k++) begin
            evs.push_back(200000 + g + 2 + TRP_DEF + k * (TRFC_DEF + 1));
        end
        evs.push_back(300000 + g + 2 + TRP_DEF + 2 * (TRFC_DEF + 1));
        foreach (evs[i]) begin
            if (which == 1) q1.push_back(evs[i]);
            else q2.push_back(evs[i]);
        end
    endtask

    task automatic scoreEvent(input int which, input int kind);
        int obs;
        int exp;
        obs = kind * 100000 + edge_n;
        if (which == 1) exp = (q1.size() > 0) ? q1.pop_front() : 0;
        else exp = (q2.size() > 0) ? q2.pop_front() : 0;
        checkOutput((which == 1) ? "dut1_event" : "dut2_event", obs, exp);
    endtask

    always @(negedge aref_clk) begin
        if (edge_n >= 1) begin
            if (cmd1 !== CMD_NOP) begin
                scoreEvent(1, (cmd1 === CMD_PRE) ? 1 : (cmd1 === CMD_AR) ? 2 : 9);
                checkOutput("dut1_bank_addr", {bank1, addr1}, {BANK_ALL, ADDR_ALL});
            end
            if (end1 !== 1'b0) scoreEvent(1, (end1 === 1'b1) ? 3 : 9);
            if (cmd2 !== CMD_NOP) begin
                scoreEvent(2, (cmd2 === CMD_PRE) ? 1 : (cmd2 === CMD_AR) ? 2 : 9);
                checkOutput("dut2_bank_addr", {bank2, addr2}, {BANK_ALL, ADDR_ALL});
            end
            if (end2 !== 1'b0) scoreEvent(2, (end2 === 1'b1) ? 3 : 9);
        end
    end

    // Short interval: requests arrive back to back, including during sequences
    initial begin
        rst2_n = 1'b0;
        init2  = 1'b0;
        en2    = 1'b1;
        waitUntilEdge(3);
        rst2_n = 1'b1;
        init2  = 1'b1;
        pushSequence(2, 3 + REF2 + 1);
        pushSequence(2, 45);
        pushSequence(2, 66);
        waitUntilEdge(3 + REF2 - 1);
        checkOutput("dut2_req_before_expiry", req2, 1'b0);
        waitUntilEdge(3 + REF2);
        checkOutput("dut2_req_first", req2, 1'b1);
        waitUntilEdge(24);
        checkOutput("dut2_req_cleared_on_grant", req2, 1'b0);
        waitUntilEdge(43);
        checkOutput("dut2_req_rise_on_end_entry", req2, 1'b1);
        waitUntilEdge(44);
        checkOutput("dut2_req_held_at_end", req2, 1'b1);
        waitUntilEdge(45);
        checkOutput("dut2_req_cleared_second_grant", req2, 1'b0);
        waitUntilEdge(63);
        checkOutput("dut2_req_rise_mid_sequence", req2, 1'b1);
        waitUntilEdge(66);
        checkOutput("dut2_req_cleared_third_grant", req2, 1'b0);
        en2 = 1'b0;
        waitUntilEdge(90);
        init2 = 1'b0;
        waitUntilEdge(92);
        done2 = 1'b1;
    end

    initial begin
        int lows;
        applyStimulus(1'b0, 1'b1, 1'b1);
        waitUntilEdge(3);
        checkOutput("reset_cmd", cmd1, CMD_NOP);
        checkOutput("reset_bank", bank1, BANK_ALL);
        checkOutput("reset_addr", addr1, ADDR_ALL);
        checkOutput("reset_req", req1, 1'b0);
        checkOutput("reset_end", end1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        waitUntilEdge(5);
        checkOutput("idle_req_init_low", req1, 1'b0);

        // Basic refresh: init_end rises at edge 5, grant is tied high
        applyStimulus(1'b1, 1'b1, 1'b1);
        waitUntilEdge(5 + REF1 - 1);
        checkOutput("basic_req_before_expiry", req1, 1'b0);
        waitUntilEdge(5 + REF1);
        checkOutput("basic_req_first", req1, 1'b1);
        pushSequence(1, 5 + REF1 + 1);
        waitUntilEdge(5 + REF1 + 1);
        checkOutput("basic_req_cleared", req1, 1'b0);
        waitUntilEdge(777);
        checkOutput("basic_idle_cmd", cmd1, CMD_NOP);
        checkOutput("basic_end_one_cycle", end1, 1'b0);

        // Withheld grant: two expiries while the request is pending
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitUntilEdge(1504);
        checkOutput("withheld_req_before", req1, 1'b0);
        lows = 0;
        for (int k = 1505; k <= 2377; k++) begin
            waitUntilEdge(k);
            if (req1 !== 1'b1) lows++;
        end
        checkOutput("withheld_req_low_cycles", lows, 0);
        pushSequence(1, 2378);
        applyStimulus(1'b1, 1'b1, 1'b1);
        waitUntilEdge(2400);
        checkOutput("withheld_req_after_seq", req1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);

        // Abort during the first TRFC wait
        waitUntilEdge(3010);
        checkOutput("abort_req_pending", req1, 1'b1);
        q1.push_back(100000 + 3012);
        q1.push_back(200000 + 3015);
        applyStimulus(1'b1, 1'b1, 1'b1);
        waitUntilEdge(3017);
        applyStimulus(1'b1, 1'b0, 1'b1);
        waitUntilEdge(3018);
        checkOutput("abort_req", req1, 1'b0);
        waitUntilEdge(3019);
        checkOutput("abort_cmd", cmd1, CMD_NOP);
        checkOutput("abort_addr", addr1, ADDR_ALL);
        checkOutput("abort_end", end1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitUntilEdge(3041);
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitUntilEdge(3795);
        checkOutput("abort_req_set_again", req1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitUntilEdge(3796);
        checkOutput("abort_req_cleared", req1, 1'b0);

        // Reset in the middle of the precharge wait
        waitUntilEdge(3800);
        applyStimulus(1'b1, 1'b1, 1'b0);
        waitUntilEdge(4551);
        checkOutput("midrst_req_pending", req1, 1'b1);
        waitUntilEdge(4552);
        q1.push_back(100000 + 4554);
        applyStimulus(1'b1, 1'b1, 1'b1);
        waitUntilEdge(4554);
        applyStimulus(1'b0, 1'b1, 1'b1);
        waitUntilEdge(4555);
        checkOutput("midrst_cmd", cmd1, CMD_NOP);
        checkOutput("midrst_req", req1, 1'b0);
        checkOutput("midrst_bank_addr", {bank1, addr1}, {BANK_ALL, ADDR_ALL});
        waitUntilEdge(4557);
        applyStimulus(1'b1, 1'b1, 1'b1);
        waitUntilEdge(4557 + REF1 - 1);
        checkOutput("midrst_timer_restart_early", req1, 1'b0);
        waitUntilEdge(4557 + REF1);
        checkOutput("midrst_timer_restart", req1, 1'b1);
        pushSequence(1, 4557 + REF1 + 1);
        waitUntilEdge(5335);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitUntilEdge(5337);

        wait (done2);
        checkOutput("dut1_events_left", q1.size(), 0);
        checkOutput("dut2_events_left", q2.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
